// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : PC register, instruction-fetch handshake and next-PC selection
//            (sequential, branch, trap, halt) for the single-cycle core.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Trap,
    input  logic        Halt,
    input  logic        Resume,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Pc,
    output logic [31:0] PcPlus4,
    output logic        InstrValid,
    output logic        MisalignErr,
    output logic [31:0] InstRet
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] r_instret;
    logic [31:0] w_instret_nxt;
    logic        r_misalign;
    logic        w_misalign_nxt;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_instret  <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instret  <= w_instret_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // EXEC event priority: stall, trap, misaligned branch, halt, branch, sequential.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instret_nxt  = r_instret;
        w_misalign_nxt = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!Stall) begin
                    w_state_nxt = S_FETCH;
                    if (Trap) begin
                        w_pc_nxt = TRAP_VECTOR;
                    end else if (Branch && (BranchTarget[1:0] != 2'b00)) begin
                        w_pc_nxt       = TRAP_VECTOR;
                        w_misalign_nxt = 1'b1;
                    end else if (Halt) begin
                        w_pc_nxt      = w_pc_plus4;
                        w_instret_nxt = r_instret + 32'd1;
                        w_state_nxt   = S_HALT;
                    end else if (Branch) begin
                        w_pc_nxt      = BranchTarget;
                        w_instret_nxt = r_instret + 32'd1;
                    end else begin
                        w_pc_nxt      = w_pc_plus4;
                        w_instret_nxt = r_instret + 32'd1;
                    end
                end
            end
            S_HALT: begin
                if (Resume) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign Pc          = r_pc;
    assign PcPlus4     = w_pc_plus4;
    assign InstrValid  = (r_state == S_EXEC);
    assign MisalignErr = r_misalign;
    assign InstRet     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Directed self-checking bench for pc_gen with a fetch-address scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        Stall;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        Trap;
    logic        Halt;
    logic        Resume;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] Pc;
    logic [31:0] PcPlus4;
    logic        InstrValid;
    logic        MisalignErr;
    logic [31:0] InstRet;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    pc_gen #(
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0004)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Stall       (Stall),
        .Branch      (Branch),
        .BranchTarget(BranchTarget),
        .Trap        (Trap),
        .Halt        (Halt),
        .Resume      (Resume),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .Pc          (Pc),
        .PcPlus4     (PcPlus4),
        .InstrValid  (InstrValid),
        .MisalignErr (MisalignErr),
        .InstRet     (InstRet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        exp_q.push_back(a);
    endtask

    // Scoreboard: every accepted fetch must match the next expected address.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                chk("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
            end else begin
                chk("fetch_addr", imem_addr, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; Stall = 1'b0; Branch = 1'b0; BranchTarget = 32'd0;
        Trap = 1'b0; Halt = 1'b0; Resume = 1'b0; imem_ack = 1'b0;
        #1;
        chk("rst_pc",       Pc,          32'h0);
        chk("rst_req",      {31'd0, imem_req},    32'd0);
        chk("rst_valid",    {31'd0, InstrValid},  32'd0);
        chk("rst_misalign", {31'd0, MisalignErr}, 32'd0);
        chk("rst_instret",  InstRet,     32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);

        // Back-to-back sequential fetches with ack tied high
        imem_ack = 1'b1;
        push(32'h0); push(32'h4); push(32'h8);
        cyc();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        cyc();
        chk("exec_valid", {31'd0, InstrValid}, 32'd1);
        cyc(); cyc(); cyc(); cyc();
        imem_ack = 1'b0;
        cyc();
        chk("seq_instret", InstRet, 32'd3);
        chk("seq_pc", Pc, 32'hC);

        // Aligned branch
        imem_ack = 1'b1; push(32'hC);
        cyc();
        imem_ack = 1'b0; Branch = 1'b1; BranchTarget = 32'h100;
        cyc();
        Branch = 1'b0;
        chk("br_pc", imem_addr, 32'h100);
        chk("br_instret", InstRet, 32'd4);
        chk("br_misalign", {31'd0, MisalignErr}, 32'd0);

        // Misaligned branch
        imem_ack = 1'b1; push(32'h100);
        cyc();
        imem_ack = 1'b0; Branch = 1'b1; BranchTarget = 32'h102;
        cyc();
        Branch = 1'b0;
        chk("mis_pc", Pc, 32'h4);
        chk("mis_pulse", {31'd0, MisalignErr}, 32'd1);
        chk("mis_instret", InstRet, 32'd4);
        cyc();
        chk("mis_pulse_end", {31'd0, MisalignErr}, 32'd0);

        // Delayed ack: request held stable through four FETCH cycles
        imem_ack = 1'b1; push(32'h4);
        cyc();
        imem_ack = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h8);
            if (i < 3) cyc();
        end
        imem_ack = 1'b1; push(32'h8);
        cyc();
        imem_ack = 1'b0; Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_valid", {31'd0, InstrValid}, 32'd1);
            chk("stall_pc", Pc, 32'h8);
            chk("stall_instret", InstRet, 32'd5);
        end
        Stall = 1'b0;
        cyc();
        chk("stall_done_pc", Pc, 32'hC);
        chk("stall_done_instret", InstRet, 32'd6);

        // Stall and trap together: stall first, then trap
        imem_ack = 1'b1; push(32'hC);
        cyc();
        imem_ack = 1'b0; Stall = 1'b1; Trap = 1'b1;
        cyc();
        chk("st_trap_hold_pc", Pc, 32'hC);
        chk("st_trap_hold_valid", {31'd0, InstrValid}, 32'd1);
        Stall = 1'b0;
        cyc();
        Trap = 1'b0;
        chk("trap_pc", Pc, 32'h4);
        chk("trap_instret", InstRet, 32'd6);
        chk("trap_misalign", {31'd0, MisalignErr}, 32'd0);

        // Halt at 0x20, then resume
        imem_ack = 1'b1; push(32'h4);
        cyc();
        imem_ack = 1'b0; Branch = 1'b1; BranchTarget = 32'h20;
        cyc();
        Branch = 1'b0;
        imem_ack = 1'b1; push(32'h20);
        cyc();
        imem_ack = 1'b0; Halt = 1'b1;
        cyc();
        Halt = 1'b0;
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_pc", Pc, 32'h24);
        chk("halt_instret", InstRet, 32'd8);
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        chk("halt_ack_ignored_req", {31'd0, imem_req}, 32'd0);
        chk("halt_ack_ignored_valid", {31'd0, InstrValid}, 32'd0);
        Resume = 1'b1;
        cyc();
        Resume = 1'b0;
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h24);

        // Wrap from top of the address space
        imem_ack = 1'b1; push(32'h24);
        cyc();
        imem_ack = 1'b0; Branch = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        cyc();
        Branch = 1'b0;
        chk("top_pc", Pc, 32'hFFFF_FFFC);
        chk("top_plus4", PcPlus4, 32'h0);
        imem_ack = 1'b1; push(32'hFFFF_FFFC);
        cyc();
        imem_ack = 1'b0;
        cyc();
        chk("wrap_pc", Pc, 32'h0);
        chk("wrap_instret", InstRet, 32'd10);

        // Asynchronous reset mid-FETCH at 0x40
        imem_ack = 1'b1; push(32'h0);
        cyc();
        imem_ack = 1'b0; Branch = 1'b1; BranchTarget = 32'h40;
        cyc();
        Branch = 1'b0;
        chk("pre_rst_pc", Pc, 32'h40);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_pc", Pc, 32'h0);
        chk("async_rst_instret", InstRet, 32'd0);
        #1;
        rst_n = 1'b1;
        push(32'h0);
        cyc();
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        cyc();
        imem_ack = 1'b0;
        chk("post_rst_valid", {31'd0, InstrValid}, 32'd1);
        cyc();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Program-counter generator and instruction-fetch sequencer for the single-cycle RISC-V core. It owns the architectural PC register, drives the instruction-memory request/acknowledge handshake, and computes the next PC from sequential, branch/jump, trap and halt events. Its `Pc` output is the PC operand consumed by the ALU operand-select stage; its `PcPlus4` output feeds JAL/JALR link write-back.

## Interface
- `RESET_VECTOR`, default `32'h0000_0000`: PC loaded on reset.
- `TRAP_VECTOR`, default `32'h0000_0004`: PC loaded on trap or misaligned target.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `Stall`, in, 1: freeze PC and state while in EXEC.
- `Branch`, in, 1: taken branch/jump this instruction.
- `BranchTarget`, in, 32: redirect address, valid when `Branch`=1.
- `Trap`, in, 1: illegal instruction; redirect to `TRAP_VECTOR`.
- `Halt`, in, 1: ecall/ebreak; enter HALT after commit.
- `Resume`, in, 1: leave HALT.
- `imem_ack`, in, 1: instruction memory has returned data for `imem_addr`.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address, always equal to `Pc`.
- `Pc`, out, 32: current instruction address.
- `PcPlus4`, out, 32: `Pc + 4`, modulo 2^32.
- `InstrValid`, out, 1: fetched instruction is being executed this cycle.
- `MisalignErr`, out, 1: one-cycle pulse on a misaligned branch target.
- `InstRet`, out, 32: retired-instruction counter.

## Operation
- States: BOOT, FETCH, EXEC, HALT.
- BOOT: entered on reset. `imem_req`=0. Unconditionally goes to FETCH on the next edge.
- FETCH: `imem_req`=1 and `imem_addr`=`Pc`, both held stable until `imem_ack`. On `imem_ack`=1 go to EXEC. `imem_ack` in any other state is ignored.
- EXEC: `InstrValid`=1. The event is chosen at the clock edge, highest priority first:
  1. `Stall`: hold everything and stay in EXEC.
  2. `Trap`: `Pc`←`TRAP_VECTOR`, go to FETCH, no retire.
  3. `Branch` with `BranchTarget[1:0]`≠0: `Pc`←`TRAP_VECTOR`, `MisalignErr` pulses for one cycle, go to FETCH, no retire.
  4. `Halt`: `Pc`←`PcPlus4`, retire, go to HALT.
  5. `Branch`: `Pc`←`BranchTarget`, retire, go to FETCH.
  6. Otherwise: `Pc`←`PcPlus4`, retire, go to FETCH.
- HALT: `imem_req`=0 and `Pc` is held. On `Resume`=1 go to FETCH.
- Retire means `InstRet`←`InstRet`+1, wrapping from `FFFF_FFFF` to 0.
- PC arithmetic is 32-bit unsigned with wrap: `FFFF_FFFC` + 4 = `0000_0000`. `PcPlus4` is combinational from `Pc`.

## Timing
- Reset values, applied immediately on `rst_n` low regardless of clock:
  - state = BOOT
  - `Pc` = `RESET_VECTOR`
  - `imem_req` = 0
  - `InstrValid` = 0
  - `MisalignErr` = 0
  - `InstRet` = 0
- Reset asserted mid-fetch drops `imem_req` at once. An outstanding ack is discarded.
- Minimum instruction period is 2 cycles: FETCH with same-cycle ack, then EXEC. Each extra cycle of ack wait adds 1 cycle.
- First `imem_req` rises 1 cycle after `rst_n` deasserts.
- `Pc` updates on the edge that leaves EXEC. The new `Pc` is visible in the following FETCH cycle.
- `MisalignErr` is registered: it is high in the FETCH cycle immediately following the redirect.
- Stall held for N cycles extends EXEC by N cycles; `InstRet` increments exactly once per instruction.
- `Stall` and `Trap` asserted together: the stall wins. The trap is taken on the first non-stalled EXEC edge if it is still asserted.

## Test plan
- Reset release with `imem_ack` tied high: `imem_addr` sequence is 0x0, 0x4, 0x8 on alternate cycles, and `InstRet` = 3 after 6 cycles following BOOT.
- `Branch`=1 with `BranchTarget`=0x100 in EXEC: next FETCH has `imem_addr`=0x100, and `InstRet` increments.
- `Branch`=1 with `BranchTarget`=0x102: `Pc`=`TRAP_VECTOR`, `MisalignErr` high for exactly 1 cycle, and `InstRet` is unchanged.
- `imem_ack` delayed 3 cycles: `imem_req` and `imem_addr` are stable across all 4 FETCH cycles. Then `Stall` held for 2 cycles in EXEC: `Pc` is held and `InstRet` increments once.
- `Halt` at `Pc`=0x20: state HALT, `imem_req`=0, `Pc`=0x24. Pulsing `Resume` gives a fetch at 0x24. Sequential execution from `Pc`=0xFFFF_FFFC wraps the next fetch to 0x0.
- `rst_n` pulsed low mid-FETCH with `Pc`=0x40: `imem_req` drops asynchronously, and `Pc`=`RESET_VECTOR` and `InstRet`=0 before the next clock edge.
